midi_note_ctrl: RTL and testbench

MIDI_NOTE_CTRL -- requirements
Module: midi_note_ctrl

---
 rtl/midi_note_ctrl_if.sv | 9 +
 rtl/midi_note_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_midi_note_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_note_ctrl_if.sv
// Byte-stream handshake between a MIDI byte source and midi_note_ctrl.
interface midi_note_ctrl_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/midi_note_ctrl.sv
// MIDI byte parser feeding a monophonic voice FSM that drives an envelope
// generator with note_on/note_off pulses and tracks a pending note.
module midi_note_ctrl #(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic                   clk,
  input  logic                   rst_b,
  midi_note_ctrl_if.slave        bus,
  input  logic                   eg_busy,
  input  logic                   eg_done,
  output logic                   note_on,
  output logic                   note_off,
  output logic                   gate,
  output logic [6:0]             note,
  output logic [6:0]             velocity,
  output logic [7:0]             drop_cnt
);

  localparam logic [1:0] P_STATUS = 2'd0;
  localparam logic [1:0] P_DATA1  = 2'd1;
  localparam logic [1:0] P_DATA2  = 2'd2;

  localparam logic [1:0] V_IDLE = 2'd0;
  localparam logic [1:0] V_HELD = 2'd1;
  localparam logic [1:0] V_REL  = 2'd2;
  localparam logic [1:0] V_PEND = 2'd3;

  logic [1:0] p_state;
  logic       rs_valid;
  logic [7:0] rs;
  logic [6:0] d1;
  logic       rdy;

  logic       ev_valid;
  logic       ev_on;
  logic [6:0] ev_key;
  logic [6:0] ev_vel;

  logic       accept;
  logic [7:0] b;
  logic       is_chan;
  logic       is_sys;
  logic       is_data;
  logic       one_byte;
  logic       data1;
  logic       data2;
  logic       complete;
  logic       note_msg;

  assign bus.byte_ready = rdy;
  assign accept   = bus.byte_valid & rdy;
  assign b        = bus.byte_in;
  assign is_data  = ~b[7];
  assign is_chan  = b[7] & (b[7:4] != 4'hF);
  assign is_sys   = (b[7:4] == 4'hF) & ~b[3];
  assign one_byte = (rs[7:4] == 4'hC) | (rs[7:4] == 4'hD);
  // P_STATUS with valid running status behaves exactly like P_DATA1
  assign data1    = is_data & rs_valid & (p_state != P_DATA2);
  assign data2    = is_data & (p_state == P_DATA2);
  assign complete = accept & ((data1 & one_byte) | data2);
  assign note_msg = ((rs[7:4] == 4'h8) | (rs[7:4] == 4'h9)) & (rs[3:0] == CHANNEL);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      p_state  <= P_STATUS;
      rs_valid <= 1'b0;
      rs       <= '0;
      d1       <= '0;
      rdy      <= 1'b0;
      ev_valid <= 1'b0;
      ev_on    <= 1'b0;
      ev_key   <= '0;
      ev_vel   <= '0;
    end else begin
      rdy      <= ~complete;
      ev_valid <= accept & data2 & note_msg;
      if (accept) begin
        if (is_chan) begin
          rs       <= b;
          rs_valid <= 1'b1;
          p_state  <= P_DATA1;
        end else if (is_sys) begin
          rs_valid <= 1'b0;
          p_state  <= P_STATUS;
        end else if (data1) begin
          if (one_byte) begin
            p_state <= P_STATUS;
          end else begin
            d1      <= b[6:0];
            p_state <= P_DATA2;
          end
        end else if (data2) begin
          p_state <= P_STATUS;
          ev_on   <= rs[4] & (b[6:0] != 7'd0);
          ev_key  <= d1;
          ev_vel  <= b[6:0];
        end
      end
    end
  end

  logic [1:0] v_state;
  logic [1:0] v_next;
  logic [6:0] pend_key;
  logic [6:0] pend_vel;
  logic [6:0] note_n;
  logic [6:0] vel_n;
  logic [6:0] pkey_n;
  logic [6:0] pvel_n;
  logic       on_n;
  logic       off_n;
  logic       drop_inc;
  logic       on_ev;
  logic       off_ev;

  assign on_ev  = ev_valid & ev_on;
  assign off_ev = ev_valid & ~ev_on;
  assign gate   = (v_state == V_HELD) | (v_state == V_PEND);

  always_comb begin
    v_next   = v_state;
    note_n   = note;
    vel_n    = velocity;
    pkey_n   = pend_key;
    pvel_n   = pend_vel;
    on_n     = 1'b0;
    off_n    = 1'b0;
    drop_inc = 1'b0;
    case (v_state)
      V_IDLE: begin
        if (on_ev) begin
          if (!eg_busy) begin
            note_n = ev_key;
            vel_n  = ev_vel;
            on_n   = 1'b1;
            v_next = V_HELD;
          end else begin
            pkey_n = ev_key;
            pvel_n = ev_vel;
            v_next = V_PEND;
          end
        end
      end
      V_HELD: begin
        if (on_ev) begin
          drop_inc = 1'b1;
        end else if (off_ev && ev_key == note) begin
          off_n  = 1'b1;
          v_next = V_REL;
        end
      end
      V_REL: begin
        // A note-on coinciding with eg_done is issued at once instead of
        // parking in V_PEND, where no further eg_done would arrive.
        if (on_ev) begin
          if (eg_done) begin
            note_n = ev_key;
            vel_n  = ev_vel;
            on_n   = 1'b1;
            v_next = V_HELD;
          end else begin
            pkey_n = ev_key;
            pvel_n = ev_vel;
            v_next = V_PEND;
          end
        end else if (eg_done) begin
          v_next = V_IDLE;
        end
      end
      V_PEND: begin
        if (on_ev) begin
          pkey_n   = ev_key;
          pvel_n   = ev_vel;
          drop_inc = 1'b1;
          if (eg_done) begin
            note_n = ev_key;
            vel_n  = ev_vel;
            on_n   = 1'b1;
            v_next = V_HELD;
          end
        end else if (off_ev && ev_key == pend_key) begin
          v_next = eg_done ? V_IDLE : V_REL;
        end else if (eg_done) begin
          note_n = pend_key;
          vel_n  = pend_vel;
          on_n   = 1'b1;
          v_next = V_HELD;
        end
      end
      default: v_next = V_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      v_state  <= V_IDLE;
      note     <= '0;
      velocity <= '0;
      pend_key <= '0;
      pend_vel <= '0;
      note_on  <= 1'b0;
      note_off <= 1'b0;
      drop_cnt <= '0;
    end else begin
      v_state  <= v_next;
      note     <= note_n;
      velocity <= vel_n;
      pend_key <= pkey_n;
      pend_vel <= pvel_n;
      note_on  <= on_n;
      note_off <= off_n;
      if (drop_inc && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_midi_note_ctrl.sv
// Self-checking bench for midi_note_ctrl: directed vector table, corner
// sequences and random traffic against a message-level reference model.
module tb_midi_note_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       eg_busy = 1'b0;
  logic       eg_done = 1'b0;
  logic       note_on, note_off, gate;
  logic [6:0] note, velocity;
  logic [7:0] drop_cnt;

  midi_note_ctrl_if bus ();

  midi_note_ctrl #(.CHANNEL(4'd0)) dut (
    .clk(clk), .rst_b(rst_b), .bus(bus), .eg_busy(eg_busy), .eg_done(eg_done),
    .note_on(note_on), .note_off(note_off), .gate(gate), .note(note),
    .velocity(velocity), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (message level) ----------------
  typedef enum int {M_IDLE, M_HELD, M_REL, M_PEND} mst_t;
  mst_t       m_st;
  int         m_rs;
  int         m_have;
  logic [7:0] m_data [2];
  bit         m_ev, m_ev_on;
  logic [6:0] m_ev_key, m_ev_vel;
  logic [6:0] m_note, m_vel, m_pkey, m_pvel;
  int         m_drop;
  bit         m_on, m_off, m_rdy;

  task automatic m_reset();
    m_st = M_IDLE; m_rs = -1; m_have = 0; m_ev = 0; m_ev_on = 0;
    m_ev_key = 0; m_ev_vel = 0; m_note = 0; m_vel = 0; m_pkey = 0; m_pvel = 0;
    m_drop = 0; m_on = 0; m_off = 0; m_rdy = 0;
  endtask

  task automatic m_issue(input logic [6:0] k, input logic [6:0] v);
    m_note = k; m_vel = v; m_on = 1; m_st = M_HELD;
  endtask

  task automatic m_voice(input bit ev, input bit ev_on, input logic [6:0] key,
                         input logic [6:0] vel, input bit busy, input bit done);
    bit on, off;
    on  = ev && ev_on;
    off = ev && !ev_on;
    case (m_st)
      M_IDLE: if (on) begin
        if (!busy) m_issue(key, vel);
        else begin m_pkey = key; m_pvel = vel; m_st = M_PEND; end
      end
      M_HELD: begin
        if (on) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        else if (off && key == m_note) begin m_off = 1; m_st = M_REL; end
      end
      M_REL: begin
        if (on) begin
          if (done) m_issue(key, vel);
          else begin m_pkey = key; m_pvel = vel; m_st = M_PEND; end
        end else if (done) m_st = M_IDLE;
      end
      M_PEND: begin
        if (on) begin
          m_pkey = key; m_pvel = vel;
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
          if (done) m_issue(m_pkey, m_pvel);
        end else if (off && key == m_pkey) m_st = done ? M_IDLE : M_REL;
        else if (done) m_issue(m_pkey, m_pvel);
      end
    endcase
  endtask

  // returns 1 when b finishes a channel message
  function automatic bit m_parse(input logic [7:0] b);
    int need;
    if (b >= 8'hF8) return 0;
    if (b >= 8'hF0) begin m_rs = -1; m_have = 0; return 0; end
    if (b >= 8'h80) begin m_rs = b; m_have = 0; return 0; end
    if (m_rs < 0) return 0;
    m_data[m_have] = b;
    m_have++;
    need = ((m_rs >> 4) == 12 || (m_rs >> 4) == 13) ? 1 : 2;
    if (m_have < need) return 0;
    m_have = 0;
    if (((m_rs >> 4) == 8 || (m_rs >> 4) == 9) && (m_rs % 16) == 0) begin
      m_ev     = 1;
      m_ev_on  = ((m_rs >> 4) == 9) && (m_data[1] != 0);
      m_ev_key = m_data[0][6:0];
      m_ev_vel = m_data[1][6:0];
    end
    return 1;
  endfunction

  task automatic m_edge(input bit v, input logic [7:0] b, input bit busy, input bit done);
    bit fin;
    m_on = 0; m_off = 0;
    m_voice(m_ev, m_ev_on, m_ev_key, m_ev_vel, busy, done);
    m_ev = 0;
    fin = 0;
    if (v && m_rdy) fin = m_parse(b);
    m_rdy = !fin;
  endtask

  // ---------------- drivers ----------------
  task automatic step(input bit v, input logic [7:0] b, input bit busy, input bit done);
    bus.byte_valid = v; bus.byte_in = b; eg_busy = busy; eg_done = done;
    @(posedge clk);
    #1;
    m_edge(v, b, busy, done);
    chk("model", {6'd0, bus.byte_ready, note_on, note_off, gate, note, velocity, drop_cnt},
        {6'd0, m_rdy, m_on, m_off, (m_st == M_HELD || m_st == M_PEND), m_note, m_vel, m_drop[7:0]});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = '0; eg_busy = 0; eg_done = 0;
    #1;
    m_reset();
    chk("reset_state", {13'd0, bus.byte_ready, note_on, note_off, gate, note, velocity, drop_cnt}, '0);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  typedef struct {
    bit v; logic [7:0] b; bit busy; bit done;
    bit rdy; bit on; bit off; bit gate; logic [6:0] note; logic [7:0] drop;
  } vec_t;

  function automatic vec_t mk(bit v, logic [7:0] b, bit busy, bit done, bit rdy, bit on,
                              bit off, bit g, logic [6:0] n, logic [7:0] d);
    vec_t t;
    t.v = v; t.b = b; t.busy = busy; t.done = done; t.rdy = rdy; t.on = on;
    t.off = off; t.gate = g; t.note = n; t.drop = d;
    return t;
  endfunction

  vec_t tv[$];
  bit   bsy;

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_in    = '0;
    //            v  byte  bsy dn  rdy on off gt note  drop
    tv.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 7'h00, 0));
    tv.push_back(mk(1, 8'h90, 0, 0, 1, 0, 0, 0, 7'h00, 0));
    tv.push_back(mk(1, 8'h3C, 0, 0, 1, 0, 0, 0, 7'h00, 0));
    tv.push_back(mk(1, 8'h64, 0, 0, 0, 0, 0, 0, 7'h00, 0));
    tv.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 7'h3C, 0));
    tv.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 7'h3C, 0));
    tv.push_back(mk(1, 8'h3C, 0, 0, 1, 0, 0, 1, 7'h3C, 0));
    tv.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 1, 7'h3C, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 0, 7'h3C, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 7'h3C, 0));
    tv.push_back(mk(1, 8'h90, 1, 0, 1, 0, 0, 0, 7'h3C, 0));
    tv.push_back(mk(1, 8'h45, 1, 0, 1, 0, 0, 0, 7'h3C, 0));
    tv.push_back(mk(1, 8'h20, 1, 0, 0, 0, 0, 0, 7'h3C, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 7'h3C, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 7'h3C, 0));
    tv.push_back(mk(0, 8'h00, 1, 1, 1, 1, 0, 1, 7'h45, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 7'h45, 0));
    tv.push_back(mk(1, 8'h91, 1, 0, 1, 0, 0, 1, 7'h45, 0));
    tv.push_back(mk(1, 8'h30, 1, 0, 1, 0, 0, 1, 7'h45, 0));
    tv.push_back(mk(1, 8'h50, 1, 0, 0, 0, 0, 1, 7'h45, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 7'h45, 0));
    tv.push_back(mk(1, 8'h90, 1, 0, 1, 0, 0, 1, 7'h45, 0));
    tv.push_back(mk(1, 8'hF8, 1, 0, 1, 0, 0, 1, 7'h45, 0));
    tv.push_back(mk(1, 8'h40, 1, 0, 1, 0, 0, 1, 7'h45, 0));
    tv.push_back(mk(1, 8'h7F, 1, 0, 0, 0, 0, 1, 7'h45, 0));
    tv.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 7'h45, 1));
    tv.push_back(mk(1, 8'h80, 0, 0, 1, 0, 0, 1, 7'h45, 1));
    tv.push_back(mk(1, 8'h3C, 0, 0, 1, 0, 0, 1, 7'h45, 1));
    tv.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 1, 7'h45, 1));
    tv.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 7'h45, 1));
    tv.push_back(mk(1, 8'h45, 0, 0, 1, 0, 0, 1, 7'h45, 1));
    tv.push_back(mk(1, 8'h40, 0, 0, 0, 0, 0, 1, 7'h45, 1));
    tv.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 7'h45, 1));
    tv.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 7'h45, 1));
    tv.push_back(mk(1, 8'h90, 0, 0, 1, 0, 0, 0, 7'h45, 1));
    tv.push_back(mk(1, 8'h3C, 0, 0, 1, 0, 0, 0, 7'h45, 1));
    tv.push_back(mk(1, 8'h01, 0, 0, 0, 0, 0, 0, 7'h45, 1));
    tv.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 7'h3C, 1));
    tv.push_back(mk(1, 8'hF0, 0, 0, 1, 0, 0, 1, 7'h3C, 1));
    tv.push_back(mk(1, 8'h3C, 0, 0, 1, 0, 0, 1, 7'h3C, 1));
    tv.push_back(mk(1, 8'h64, 0, 0, 1, 0, 0, 1, 7'h3C, 1));
    tv.push_back(mk(1, 8'hF7, 0, 0, 1, 0, 0, 1, 7'h3C, 1));
    tv.push_back(mk(1, 8'h3C, 0, 0, 1, 0, 0, 1, 7'h3C, 1));
    tv.push_back(mk(1, 8'h64, 0, 0, 1, 0, 0, 1, 7'h3C, 1));
    tv.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 7'h3C, 1));

    // directed table
    do_reset();
    foreach (tv[i]) begin
      step(tv[i].v, tv[i].b, tv[i].busy, tv[i].done);
      chk($sformatf("row%0d", i),
          {13'd0, bus.byte_ready, note_on, note_off, gate, note, drop_cnt},
          {13'd0, tv[i].rdy, tv[i].on, tv[i].off, tv[i].gate, tv[i].note, tv[i].drop});
      if (i == 4) chk("velocity_64", {25'd0, velocity}, 32'h64);
    end

    // drop counter saturation
    do_reset();
    step(0, 8'h00, 0, 0);
    step(1, 8'h90, 0, 0); step(1, 8'h3C, 0, 0); step(1, 8'h64, 0, 0);
    step(0, 8'h00, 0, 0); step(0, 8'h00, 0, 0);
    for (int i = 1; i <= 300; i++) begin
      step(1, 8'h40, 0, 0); step(1, 8'h50, 0, 0);
      step(0, 8'h00, 0, 0); step(0, 8'h00, 0, 0);
      if (i == 254 || i == 255 || i == 300)
        chk($sformatf("drop_after_%0d", i), {24'd0, drop_cnt}, (i < 255) ? i : 255);
    end

    // reset while a note is held: no note_off, everything cleared
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    m_reset();
    chk("rst_mid_note", {13'd0, bus.byte_ready, note_on, note_off, gate, note, velocity, drop_cnt}, '0);
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);

    // reset between status and data: later data bytes have no running status
    step(1, 8'h90, 0, 0);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    m_reset();
    chk("rst_mid_msg", {13'd0, bus.byte_ready, note_on, note_off, gate, note, velocity, drop_cnt}, '0);
    @(negedge clk);
    rst_b = 1'b1;
    step(0, 8'h00, 0, 0);
    step(1, 8'h3C, 0, 0); step(1, 8'h64, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 0, 0);
      chk("no_event_after_rst", {30'd0, note_on, gate}, '0);
    end

    // random traffic against the model
    do_reset();
    bsy = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 8)       b = 8'h90 | (($urandom_range(0, 2) == 2) ? 8'h01 : 8'h00);
      else if (r < 14) b = 8'h80 | (($urandom_range(0, 2) == 2) ? 8'h01 : 8'h00);
      else if (r < 16) b = 8'hB0 + 8'($urandom_range(0, 2)) * 8'h10;
      else if (r < 18) b = 8'hF0 + 8'($urandom_range(0, 7));
      else if (r < 22) b = 8'hF8 + 8'($urandom_range(0, 7));
      else if ($urandom_range(0, 9) < 2) b = 8'h00;
      else b = 8'h3C + 8'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) bsy = ~bsy;
      step($urandom_range(0, 9) < 7, b, bsy, $urandom_range(0, 99) < 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
